// File: rtl/dca_matrix_lsu_row_unpacker_pkg.sv
// Shared LSU definitions: rresp_info field widths and order, element width codes, and helpers.
package dca_matrix_lsu_row_unpacker_pkg;

  localparam int DCA_BW_LSU_ELEMENT          = 32;
  localparam int MAX_BW_MEMORY_SINGLE_DEFAULT = 32;

  // rresp_info = {col_mask, addr_lsa_p3, is_float, is_signed, ncol_m1, nrow_m1, stride_ls3, addr, opcode}
  localparam int BW_RRESP_OPCODE = 3;
  localparam int BW_RRESP_ADDR   = 32;
  localparam int BW_RRESP_STRIDE = 32;
  localparam int BW_RRESP_LSA    = 3;

  localparam logic [2:0] DCA_ELEM_W1  = 3'd0;
  localparam logic [2:0] DCA_ELEM_W2  = 3'd1;
  localparam logic [2:0] DCA_ELEM_W4  = 3'd2;
  localparam logic [2:0] DCA_ELEM_W8  = 3'd3;
  localparam logic [2:0] DCA_ELEM_W16 = 3'd4;
  localparam logic [2:0] DCA_ELEM_W32 = 3'd5;

  function automatic int bw_rresp_idx(input int ncol);
    return (ncol > 1) ? $clog2(ncol) : 1;
  endfunction

  function automatic int bw_rresp_info(input int ncol);
    return ncol + BW_RRESP_LSA + 2 + 2 * bw_rresp_idx(ncol)
         + BW_RRESP_STRIDE + BW_RRESP_ADDR + BW_RRESP_OPCODE;
  endfunction

  // Reserved codes 6/7 map onto the widest element.
  function automatic logic [2:0] clamp_width_code(input logic [2:0] code);
    return (code > DCA_ELEM_W32) ? DCA_ELEM_W32 : code;
  endfunction

  function automatic logic [31:0] width_mask(input logic [2:0] code);
    case (code)
      DCA_ELEM_W1:  return 32'h0000_0001;
      DCA_ELEM_W2:  return 32'h0000_0003;
      DCA_ELEM_W4:  return 32'h0000_000F;
      DCA_ELEM_W8:  return 32'h0000_00FF;
      DCA_ELEM_W16: return 32'h0000_FFFF;
      default:      return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/dca_lsu_element_extend.sv
// One column of the unpacker: keeps the low bits of a slice at the coded width,
// sign/zero-extends them to the element width, and zeroes disabled columns. Combinational.
module dca_lsu_element_extend
  import dca_matrix_lsu_row_unpacker_pkg::*;
#(
  parameter int BW_ELEMENT = DCA_BW_LSU_ELEMENT
) (
  input  logic [MAX_BW_MEMORY_SINGLE_DEFAULT-1:0] slice,
  input  logic [2:0]                              width_code,
  input  logic                                    is_signed,
  input  logic                                    col_en,
  output logic [BW_ELEMENT-1:0]                   element
);

  logic [31:0]           keep;
  logic                  msb;
  logic [BW_ELEMENT-1:0] slice_w;
  logic [BW_ELEMENT-1:0] keep_w;

  always_comb begin
    keep    = width_mask(width_code);
    slice_w = BW_ELEMENT'(slice);
    keep_w  = BW_ELEMENT'(keep);
    case (width_code)
      DCA_ELEM_W1:  msb = slice[0];
      DCA_ELEM_W2:  msb = slice[1];
      DCA_ELEM_W4:  msb = slice[3];
      DCA_ELEM_W8:  msb = slice[7];
      DCA_ELEM_W16: msb = slice[15];
      default:      msb = slice[31];
    endcase
    // Single-bit elements carry no sign, so they always zero-extend.
    if (!col_en)
      element = '0;
    else if (is_signed && (width_code != DCA_ELEM_W1) && msb)
      element = slice_w | ~keep_w;
    else
      element = slice_w & keep_w;
  end

endmodule

// File: rtl/dca_matrix_lsu_row_unpacker.sv
// Load-path row unpacker with a 2-entry FIFO between the packed-row and unpacked-row handshakes.
// Optional perf counters under DCA_ROW_UNPACKER_PERF_EN.
module dca_matrix_lsu_row_unpacker
  import dca_matrix_lsu_row_unpacker_pkg::*;
#(
  parameter int  MATRIX_SIZE_PARA     = 4,
  parameter int  BW_LSU_ELEMENT       = 32,
  parameter int  BW_TXN_INFO          = 8,
  localparam int MATRIX_NUM_COL       = MATRIX_SIZE_PARA,
  localparam int BW_MEMORY_ROW_BUFFER = 32 * MATRIX_NUM_COL,
  localparam int BW_RRESP_INFO        = bw_rresp_info(MATRIX_NUM_COL),
  localparam int BW_LROW              = BW_LSU_ELEMENT * MATRIX_NUM_COL
) (
  input  logic                            clk,
  input  logic                            rstnn,
  input  logic                            clear,
  input  logic                            enable,
  input  logic [BW_RRESP_INFO-1:0]        rresp_info,
  input  logic                            mrow_valid,
  output logic                            mrow_ready,
  input  logic [BW_MEMORY_ROW_BUFFER-1:0] mrow_data,
  input  logic [BW_TXN_INFO-1:0]          mrow_txn_info,
  output logic                            lrow_valid,
  input  logic                            lrow_ready,
  output logic [BW_LROW-1:0]              lrow_data,
  output logic [BW_TXN_INFO-1:0]          lrow_txn_info
`ifdef DCA_ROW_UNPACKER_PERF_EN
  ,
  output logic [31:0]                     perf_row_count,
  output logic [31:0]                     perf_stall_count
`endif
);

  localparam int OFS_SIGNED = BW_RRESP_OPCODE + BW_RRESP_ADDR + BW_RRESP_STRIDE
                            + 2 * bw_rresp_idx(MATRIX_NUM_COL);
  localparam int OFS_FLOAT  = OFS_SIGNED + 1;
  localparam int OFS_LSA    = OFS_SIGNED + 2;
  localparam int OFS_MASK   = OFS_LSA + BW_RRESP_LSA;

  logic                      is_signed;
  logic [2:0]                width_code;
  logic [MATRIX_NUM_COL-1:0] col_mask;
  logic                      unused_info;
  logic [BW_LROW-1:0]        unpacked;

  assign is_signed  = rresp_info[OFS_SIGNED];
  assign width_code = clamp_width_code(rresp_info[OFS_LSA +: BW_RRESP_LSA]);
  assign col_mask   = rresp_info[OFS_MASK +: MATRIX_NUM_COL];
  // is_float and the address/shape fields play no part in unpacking.
  assign unused_info = ^{rresp_info[OFS_FLOAT], rresp_info[OFS_SIGNED-1:0]};

  for (genvar i = 0; i < MATRIX_NUM_COL; i++) begin : g_col
    logic [MAX_BW_MEMORY_SINGLE_DEFAULT-1:0] slice;
    // Columns are packed densely at the element width, so column i starts at i << code.
    assign slice = MAX_BW_MEMORY_SINGLE_DEFAULT'(mrow_data >> (32'(i) << width_code));

    dca_lsu_element_extend #(
      .BW_ELEMENT (BW_LSU_ELEMENT)
    ) u_extend (
      .slice      (slice),
      .width_code (width_code),
      .is_signed  (is_signed),
      .col_en     (col_mask[i]),
      .element    (unpacked[BW_LSU_ELEMENT*i +: BW_LSU_ELEMENT])
    );
  end

  logic [1:0]             count;
  logic                   run;
  logic [BW_LROW-1:0]     head_data;
  logic [BW_LROW-1:0]     tail_data;
  logic [BW_TXN_INFO-1:0] head_tag;
  logic [BW_TXN_INFO-1:0] tail_tag;
  logic                   push;
  logic                   pop;

  // run keeps mrow_ready low for the whole reset period, even with enable high.
  assign mrow_ready    = enable & run & (count != 2'd2);
  assign lrow_valid    = enable & (count != 2'd0);
  assign lrow_data     = (count != 2'd0) ? head_data : '0;
  assign lrow_txn_info = (count != 2'd0) ? head_tag  : '0;
  assign push          = mrow_valid & mrow_ready;
  assign pop           = lrow_valid & lrow_ready;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      run       <= 1'b0;
      count     <= 2'd0;
      head_data <= '0;
      tail_data <= '0;
      head_tag  <= '0;
      tail_tag  <= '0;
    end else begin
      run <= 1'b1;
      if (clear) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              head_data <= unpacked;
              head_tag  <= mrow_txn_info;
            end else begin
              tail_data <= unpacked;
              tail_tag  <= mrow_txn_info;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            head_data <= tail_data;
            head_tag  <= tail_tag;
            count     <= count - 2'd1;
          end
          // Both only happen at count 1: the incoming row replaces the departing head.
          2'b11: begin
            head_data <= unpacked;
            head_tag  <= mrow_txn_info;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DCA_ROW_UNPACKER_PERF_EN
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      perf_row_count   <= '0;
      perf_stall_count <= '0;
    end else if (clear) begin
      perf_row_count   <= '0;
      perf_stall_count <= '0;
    end else if (enable) begin
      if (pop)
        perf_row_count <= perf_row_count + 32'd1;
      if (lrow_valid && !lrow_ready)
        perf_stall_count <= perf_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dca_matrix_lsu_row_unpacker.sv
// Bench for the row unpacker: vector table plus scoreboarded handshake sequences.
module tb_dca_matrix_lsu_row_unpacker;
  import dca_matrix_lsu_row_unpacker_pkg::*;

  localparam int IW = bw_rresp_info(4);

  logic          clk;
  logic          rstnn;
  logic          clear;
  logic          enable;
  logic [IW-1:0] rresp_info;
  logic          mrow_valid;
  logic          mrow_ready;
  logic [127:0]  mrow_data;
  logic [7:0]    mrow_txn_info;
  logic          lrow_valid;
  logic          lrow_ready;
  logic [127:0]  lrow_data;
  logic [7:0]    lrow_txn_info;
`ifdef DCA_ROW_UNPACKER_PERF_EN
  logic [31:0]   perf_row_count;
  logic [31:0]   perf_stall_count;
`endif

  dca_matrix_lsu_row_unpacker #(
    .MATRIX_SIZE_PARA (4),
    .BW_LSU_ELEMENT   (32),
    .BW_TXN_INFO      (8)
  ) dut (
    .clk           (clk),
    .rstnn         (rstnn),
    .clear         (clear),
    .enable        (enable),
    .rresp_info    (rresp_info),
    .mrow_valid    (mrow_valid),
    .mrow_ready    (mrow_ready),
    .mrow_data     (mrow_data),
    .mrow_txn_info (mrow_txn_info),
    .lrow_valid    (lrow_valid),
    .lrow_ready    (lrow_ready),
    .lrow_data     (lrow_data),
    .lrow_txn_info (lrow_txn_info)
`ifdef DCA_ROW_UNPACKER_PERF_EN
    ,
    .perf_row_count   (perf_row_count),
    .perf_stall_count (perf_stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   code;
    logic         sg;
    logic         fl;
    logic [3:0]   mask;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] d;
    logic [7:0]   t;
  } sb_t;

  vec_t         vecs[10];
  sb_t          sbq[$];
  logic [127:0] cur_exp;
  int           tests = 0;
  int           fails = 0;
  int           pops  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk_info(input logic [3:0] mask, input logic [2:0] code,
                                            input logic fl, input logic sg);
    return {mask, code, fl, sg, 4'($urandom), 64'({$urandom, $urandom}), 3'($urandom)};
  endfunction

  // Bit-by-bit reference: column c occupies bits [w*c, w*c+w) of the packed row.
  function automatic logic [127:0] ref_unpack(input logic [127:0] d, input logic [2:0] code,
                                              input logic sg, input logic [3:0] mask);
    int w;
    logic [127:0] r;
    r = '0;
    case (code)
      3'd0: w = 1;
      3'd1: w = 2;
      3'd2: w = 4;
      3'd3: w = 8;
      3'd4: w = 16;
      default: w = 32;
    endcase
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        for (int b = 0; b < 32; b++) begin
          if (b < w) r[32*c+b] = d[w*c+b];
          else       r[32*c+b] = (sg && code != 3'd0) ? d[w*c+w-1] : 1'b0;
        end
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    sb_t e;
    if (!rstnn || clear) begin
      sbq.delete();
    end else begin
      if (lrow_valid && lrow_ready) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got tag %h with nothing outstanding", lrow_txn_info);
        end else begin
          e = sbq.pop_front();
          chk("pop_data", lrow_data, e.d);
          chk("pop_tag", lrow_txn_info, e.t);
          pops++;
        end
      end
      if (mrow_valid && mrow_ready) sbq.push_back('{cur_exp, mrow_txn_info});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] code, input logic sg, input logic fl, input logic [3:0] mask,
                       input logic [127:0] data, input logic [127:0] exp, input logic [7:0] tag);
    rresp_info    = mk_info(mask, code, fl, sg);
    mrow_data     = data;
    mrow_txn_info = tag;
    cur_exp       = exp;
    mrow_valid    = 1'b1;
  endtask

  task automatic rand_drive(input logic [7:0] tag);
    logic [2:0]   code;
    logic         sg;
    logic [3:0]   mask;
    logic [127:0] d;
    code = 3'($urandom_range(0, 7));
    sg   = 1'($urandom);
    mask = 4'($urandom);
    d    = {$urandom, $urandom, $urandom, $urandom};
    drive(code, sg, 1'($urandom), mask, d, ref_unpack(d, code, sg, mask), tag);
  endtask

  task automatic wait_accept(input string name);
    logic acc;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      acc = mrow_valid && mrow_ready;
      tick();
      if (acc) begin
        mrow_valid = 1'b0;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL %s: row not accepted within 50 cycles", name);
    mrow_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 50; k++) begin
      if (sbq.size() == 0) break;
      tick();
    end
    chk(name, 128'(sbq.size()), 128'd0);
  endtask

  initial begin
    vecs[0] = '{3'd3, 1'b1, 1'b1, 4'hF, 128'h0000_0000_0000_0000_0000_0000_01FF_7F80,
                128'h00000001_FFFFFFFF_0000007F_FFFFFF80};
    vecs[1] = '{3'd3, 1'b0, 1'b0, 4'hF, 128'h0000_0000_0000_0000_0000_0000_01FF_7F80,
                128'h00000001_000000FF_0000007F_00000080};
    vecs[2] = '{3'd0, 1'b1, 1'b0, 4'hF, 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5B,
                128'h00000001_00000000_00000001_00000001};
    vecs[3] = '{3'd7, 1'b1, 1'b0, 4'hF, 128'h80000000_7FFFFFFF_00000001_FFFFFFFE,
                128'h80000000_7FFFFFFF_00000001_FFFFFFFE};
    vecs[4] = '{3'd6, 1'b0, 1'b1, 4'hF, 128'h80000000_7FFFFFFF_00000001_FFFFFFFE,
                128'h80000000_7FFFFFFF_00000001_FFFFFFFE};
    vecs[5] = '{3'd5, 1'b1, 1'b0, 4'b0101, 128'h44444444_83333333_22222222_91111111,
                128'h00000000_83333333_00000000_91111111};
    vecs[6] = '{3'd4, 1'b1, 1'b0, 4'hF, 128'hDEADBEEF_CAFEBABE_7FFF8000_0001FFFF,
                128'h00007FFF_FFFF8000_00000001_FFFFFFFF};
    vecs[7] = '{3'd2, 1'b1, 1'b0, 4'b1110, 128'h0000_0000_0000_0000_0000_0000_0000_F8A3,
                128'hFFFFFFFF_FFFFFFF8_FFFFFFFA_00000000};
    vecs[8] = '{3'd1, 1'b1, 1'b0, 4'hF, 128'hABCDEF01_23456789_0BADF00D_1234566C,
                128'h00000001_FFFFFFFE_FFFFFFFF_00000000};
    vecs[9] = '{3'd2, 1'b0, 1'b0, 4'hF, 128'h0000_0000_0000_0000_0000_0000_0000_F8A3,
                128'h0000000F_00000008_0000000A_00000003};

    rstnn = 1'b0; clear = 1'b0; enable = 1'b1; rresp_info = '0; mrow_valid = 1'b0;
    mrow_data = '0; mrow_txn_info = '0; lrow_ready = 1'b0; cur_exp = '0;

    #12;
    chk("reset_mrow_ready", mrow_ready, 0);
    chk("reset_lrow_valid", lrow_valid, 0);
    chk("reset_lrow_data", lrow_data, 0);
    chk("reset_lrow_txn", lrow_txn_info, 0);
    @(negedge clk) rstnn = 1'b1;
    tick(); tick();
    chk("ready_after_reset", mrow_ready, 1);

    // First-row latency: accepted at edge N, visible right after N.
    drive(vecs[0].code, vecs[0].sg, vecs[0].fl, vecs[0].mask, vecs[0].data, vecs[0].exp, 8'hA5);
    wait_accept("latency_accept");
    chk("latency_valid", lrow_valid, 1);
    chk("latency_tag", lrow_txn_info, 8'hA5);
    lrow_ready = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].code, vecs[i].sg, vecs[i].fl, vecs[i].mask, vecs[i].data, vecs[i].exp, 8'(i + 16));
      wait_accept("table_accept");
    end
    drain("table_drain");

    // Backpressure: two rows fill the buffer, third is held off until the consumer returns.
    begin
      int p0;
      p0 = pops;
      lrow_ready = 1'b0;
      rand_drive(8'd1); wait_accept("bp_accept1");
      rand_drive(8'd2); wait_accept("bp_accept2");
      rand_drive(8'd3);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("bp_mrow_ready", mrow_ready, 0);
        chk("bp_lrow_valid", lrow_valid, 1);
        chk("bp_head_tag", lrow_txn_info, 8'd1);
        chk("bp_stable_data", lrow_data, sbq[0].d);
        tick();
      end
      lrow_ready = 1'b1;
      wait_accept("bp_accept3");
      drain("bp_drain");
      chk("bp_pop_count", 128'(pops - p0), 128'd3);
    end

    // Streaming at one row per cycle.
    for (int k = 0; k < 16; k++) begin
      rand_drive(8'(8'h40 + k));
      @(negedge clk);
      chk("stream_ready", mrow_ready, 1);
      if (k > 0) chk("stream_valid", lrow_valid, 1);
      tick();
    end
    mrow_valid = 1'b0;
    drain("stream_drain");

    // Random valid/ready traffic.
    for (int k = 0; k < 300; k++) begin
      logic acc;
      lrow_ready = 1'($urandom);
      if (!mrow_valid && $urandom_range(0, 2) != 0) rand_drive(8'($urandom));
      @(negedge clk);
      acc = mrow_valid && mrow_ready;
      tick();
      if (acc) mrow_valid = 1'b0;
    end
    mrow_valid = 1'b0;
    lrow_ready = 1'b1;
    drain("random_drain");

    // Clear with a full buffer discards everything, including a same-cycle push and pop.
    lrow_ready = 1'b0;
    rand_drive(8'h71); wait_accept("clr_accept1");
    rand_drive(8'h72); wait_accept("clr_accept2");
    rand_drive(8'h73);
    lrow_ready = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0; mrow_valid = 1'b0; lrow_ready = 1'b0;
    chk("clear_lrow_valid", lrow_valid, 0);
    chk("clear_lrow_data", lrow_data, 0);
    chk("clear_mrow_ready", mrow_ready, 1);
    tick();
    chk("clear_stays_empty", lrow_valid, 0);

    // enable=0 freezes both handshakes and holds the stored row.
    rand_drive(8'h81); wait_accept("en_accept1");
    enable = 1'b0;
    rand_drive(8'h82);
    lrow_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("en_mrow_ready", mrow_ready, 0);
      chk("en_lrow_valid", lrow_valid, 0);
      chk("en_held_data", lrow_data, sbq[0].d);
      tick();
    end
    enable = 1'b1;
    wait_accept("en_accept2");
    drain("en_drain");

    // Asynchronous reset in the middle of a cycle with two rows stored.
    lrow_ready = 1'b0;
    rand_drive(8'h91); wait_accept("arst_accept1");
    rand_drive(8'h92); wait_accept("arst_accept2");
    @(posedge clk);
    #3 rstnn = 1'b0;
    #1;
    chk("arst_mrow_ready", mrow_ready, 0);
    chk("arst_lrow_valid", lrow_valid, 0);
    chk("arst_lrow_data", lrow_data, 0);
    chk("arst_lrow_txn", lrow_txn_info, 0);
    @(negedge clk) rstnn = 1'b1;
    tick(); tick();
    chk("arst_empty_after", lrow_valid, 0);

`ifdef DCA_ROW_UNPACKER_PERF_EN
    chk("perf_rows_reset", perf_row_count, 0);
    chk("perf_stall_reset", perf_stall_count, 0);
    rand_drive(8'hA1); wait_accept("perf_accept");
    tick(); tick();
    lrow_ready = 1'b1;
    tick();
    chk("perf_rows", perf_row_count, 1);
    chk("perf_stalls", perf_stall_count, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule
